aes_key_schedule_ctrl: RTL and testbench

//   Sequencer for the single-round AES-128 key-expansion datapath (AES round-key generator).
//   On start, loads the cipher key as round key 0, then drives the generator once per round with

---
 rtl/aes_key_schedule_ctrl.sv | 118 +++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: drives a single-round key generator NR times and
// keeps all NR+1 round keys in a local store for indexed readout by the cipher pipeline.
//
// state | meaning
// IDLE  | waiting for start; store holds last schedule (valid when keys_ready_o)
// LOAD  | write cipher key as round key 0, prime generator inputs
// ROUND | request held on generator; capture result, advance round number
// FIN   | done pulse, schedule marked ready on exit
module aes_key_schedule_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [KW-1:0] key_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          keys_ready_o,
  output logic [KW-1:0] gen_key_o,
  output logic [3:0]    gen_rnum_o,
  output logic          gen_valid_in_o,
  input  logic          gen_valid_out_i,
  input  logic [KW-1:0] gen_out_key_i,
  input  logic [3:0]    rd_addr_i,
  output logic [KW-1:0] rd_key_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FIN
  } state_e;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_e        state_q;
  logic [KW-1:0] key_q;
  logic [KW-1:0] store_q [NR+1];
  logic          busy_q;
  logic          done_q;
  logic          keys_ready_q;
  logic [KW-1:0] gen_key_q;
  logic [3:0]    gen_rnum_q;
  logic          gen_valid_in_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      key_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      keys_ready_q   <= 1'b0;
      gen_key_q      <= '0;
      gen_rnum_q     <= 4'd0;
      gen_valid_in_q <= 1'b0;
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            key_q        <= key_i;
            keys_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          store_q[0]     <= key_q;
          gen_key_q      <= key_q;
          gen_rnum_q     <= 4'd1;
          gen_valid_in_q <= 1'b1;
          state_q        <= S_ROUND;
        end
        S_ROUND: begin
          // Request and operands stay frozen until the generator answers.
          if (gen_valid_out_i) begin
            for (int i = 1; i <= NR; i++) begin
              if (gen_rnum_q == 4'(i)) store_q[i] <= gen_out_key_i;
            end
            gen_key_q <= gen_out_key_i;
            if (gen_rnum_q == LAST_RND) begin
              gen_valid_in_q <= 1'b0;
              gen_rnum_q     <= 4'd0;
              done_q         <= 1'b1;
              state_q        <= S_FIN;
            end else begin
              gen_rnum_q <= gen_rnum_q + 4'd1;
            end
          end
        end
        S_FIN: begin
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
          keys_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_key_o = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_addr_i == 4'(i)) rd_key_o = store_q[i];
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign keys_ready_o   = keys_ready_q;
  assign gen_key_o      = gen_key_q;
  assign gen_rnum_o     = gen_rnum_q;
  assign gen_valid_in_o = gen_valid_in_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Scoreboard bench for aes_key_schedule_ctrl with a behavioural AES-128 round-key generator.
module tb_aes_key_schedule_ctrl;
  localparam int NR = 10;
  localparam int KW = 128;
  localparam logic [KW-1:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [KW-1:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [KW-1:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [KW-1:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [KW-1:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic          busy, done, keys_ready, gen_valid_in;
  logic [KW-1:0] gen_key, gen_out_key, rd_key;
  logic [3:0]    gen_rnum;
  logic          gen_valid_out = 1'b1;
  logic [3:0]    rd_addr = 4'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  bit stall_mode = 1'b0;
  int stall_cnt = 0;

  typedef struct {
    logic [3:0]    rnum;
    logic [KW-1:0] key;
  } cap_t;
  cap_t          cap_q[$];
  int            lat_q[$];
  logic [KW-1:0] exp_rk [0:NR];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_schedule_ctrl #(.NR(NR), .KW(KW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .key_i(key_in),
    .busy_o(busy), .done_o(done), .keys_ready_o(keys_ready),
    .gen_key_o(gen_key), .gen_rnum_o(gen_rnum), .gen_valid_in_o(gen_valid_in),
    .gen_valid_out_i(gen_valid_out), .gen_out_key_i(gen_out_key),
    .rd_addr_i(rd_addr), .rd_key_o(rd_key)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    if (x == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [KW-1:0] next_rk(input logic [KW-1:0] k, input logic [3:0] rn);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc = 8'h01;
    for (int i = 1; i < int'(rn); i++) rc = xt(rc);
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign gen_out_key = next_rk(gen_key, gen_rnum);

  // Stall mode: generator answers on the 4th cycle of every request.
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      gen_valid_out = 1'b1;
    end else if (!gen_valid_in) begin
      gen_valid_out = 1'b0;
      stall_cnt     = 0;
    end else begin
      gen_valid_out = (stall_cnt == 3);
      stall_cnt     = (stall_cnt == 3) ? 0 : stall_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (gen_valid_in && gen_valid_out) begin
        checks++;
        if (cap_q.size() == 0) begin
          errors++;
          $display("FAIL cap_unexpected got rnum=%0d key=%h, none expected", gen_rnum, gen_key);
        end else begin
          cap_t c;
          c = cap_q.pop_front();
          if (gen_rnum !== c.rnum || gen_key !== c.key) begin
            errors++;
            $display("FAIL cap got rnum=%0d key=%h exp rnum=%0d key=%h",
                     gen_rnum, gen_key, c.rnum, c.key);
          end
        end
      end
      if (done) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected at cycle %0d", cyc);
        end else begin
          int lat;
          lat = lat_q.pop_front();
          if (cyc - t_start != lat || !busy || gen_valid_in) begin
            errors++;
            $display("FAIL done got lat=%0d busy=%b gvi=%b exp lat=%0d busy=1 gvi=0",
                     cyc - t_start, busy, gen_valid_in, lat);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic start_exp(input logic [KW-1:0] k, input int lat, input bit b2b);
    logic [KW-1:0] w = k;
    @(posedge clk); #1;
    if (b2b) chk("b2b_keys_ready_before", keys_ready, 1);
    start   = 1'b1;
    key_in  = k;
    t_start = cyc;
    exp_rk[0] = k;
    for (int r = 1; r <= NR; r++) begin
      cap_q.push_back(cap_t'{rnum: 4'(r), key: w});
      w = next_rk(w, 4'(r));
      exp_rk[r] = w;
    end
    lat_q.push_back(lat);
    @(posedge clk); #1;
    start = 1'b0;
    chk("keys_ready_at_accept", keys_ready, 0);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < maxc);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no done after %0d cycles exp done", nm, maxc);
    end
  endtask

  task automatic check_store(input string nm);
    @(posedge clk); #1;
    chk({nm, "_keys_ready"}, keys_ready, 1);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_done_low"}, done, 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s_rd%0d", nm, a), rd_key, (a <= NR) ? exp_rk[a] : '0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_keys_ready", keys_ready, 0);
    chk("rst_gvi", gen_valid_in, 0);
    chk("rst_rnum", gen_rnum, 0);
    chk("rst_gen_key", gen_key, 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("rst_rd%0d", a), rd_key, 0);
    end

    // Basic FIPS-197 expansion, generator always valid
    start_exp(KEY_A, 12, 1'b0);
    wait_done(20, "t1");
    check_store("t1");
    rd_addr = 4'd1;  #1; chk("t1_rk1_const", rd_key, A_RK1);
    rd_addr = 4'd10; #1; chk("t1_rk10_const", rd_key, A_RK10);

    // Second key, to make a later rewrite of the store observable
    start_exp(KEY_B, 12, 1'b0);
    wait_done(20, "tb");
    check_store("tb");
    rd_addr = 4'd10; #1; chk("tb_rk10_const", rd_key, B_RK10);

    // Stalled generator: 3 idle cycles before each acceptance
    stall_mode = 1'b1;
    start_exp(KEY_A, 42, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_keys_ready_mid", keys_ready, 0);
    for (int a = 11; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("t2_mid_rd%0d", a), rd_key, 0);
    end
    rd_addr = 4'd0; #1; chk("t2_mid_rd0", rd_key, KEY_A);
    wait_done(60, "t2");
    stall_mode = 1'b0;
    check_store("t2");
    rd_addr = 4'd10; #1; chk("t2_rk10_const", rd_key, A_RK10);

    // Stray start mid-expansion with another key
    start_exp(KEY_A, 12, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start  = 1'b1;
    key_in = KEY_B;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_done(20, "t3");
    check_store("t3");

    // Reset mid-expansion
    start_exp(KEY_B, 12, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cap_q.delete();
    lat_q.delete();
    chk("t4_busy", busy, 0);
    chk("t4_keys_ready", keys_ready, 0);
    chk("t4_gvi", gen_valid_in, 0);
    chk("t4_rnum", gen_rnum, 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("t4_rd%0d", a), rd_key, 0);
    end
    start_exp(KEY_A, 12, 1'b0);
    wait_done(20, "t4");

    // Back-to-back start in the cycle after done
    start_exp(KEY_B, 12, 1'b1);
    wait_done(20, "t5");
    check_store("t5");
    rd_addr = 4'd10; #1; chk("t5_rk10_const", rd_key, B_RK10);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 128'(cap_q.size() + lat_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
